// File: rtl/memmap_router.sv
// Address-map router: decodes a request against a programmable region table,
// hands the translated address to one device and reports completion or error.
module memmap_router #(
   parameter int ADDR_W  = 16,
   parameter int NREG    = 4,
   parameter int SEL_W   = 3,
   parameter int TIMEOUT = 15
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cfg_we,
   input  logic [$clog2(NREG)-1:0] cfg_idx,
   input  logic [ADDR_W-1:0]       cfg_base,
   input  logic [ADDR_W-1:0]       cfg_limit,
   input  logic                    cfg_en,
   input  logic                    req_valid,
   input  logic [ADDR_W-1:0]       req_addr,
   output logic                    req_ready,
   output logic                    dev_valid,
   output logic [SEL_W-1:0]        dev_sel,
   output logic [ADDR_W-1:0]       dev_addr,
   input  logic                    dev_ack,
   output logic                    resp_valid,
   output logic                    resp_err
);

   localparam int IDX_W = $clog2(NREG);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DECODE = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   // cnt_q holds the number of WAIT cycles already spent without an ack, so the
   // TIMEOUT-th WAIT cycle is the one seen with cnt_q == TIMEOUT-1.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   logic [ADDR_W-1:0] base_q  [NREG];
   logic [ADDR_W-1:0] limit_q [NREG];
   logic [NREG-1:0]   en_q;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              dev_valid_q, dev_valid_d;
   logic [SEL_W-1:0]  dev_sel_q, dev_sel_d;
   logic [ADDR_W-1:0] dev_addr_q, dev_addr_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_err_q, resp_err_d;

   logic              hit;
   logic [SEL_W-1:0]  hit_sel;
   logic [ADDR_W-1:0] hit_base;

   // NOTE: the region table is a small register file that must come out of reset
   // disabled and zeroed, so unlike a RAM every entry sits on the async reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            base_q[i]  <= '0;
            limit_q[i] <= '0;
         end
         en_q <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (cfg_we && (cfg_idx == IDX_W'(i))) begin
               base_q[i]  <= cfg_base;
               limit_q[i] <= cfg_limit;
               en_q[i]    <= cfg_en;
            end
         end
      end
   end

   // Scanning from the top down lets the lowest matching index overwrite the rest.
   // NOTE: every always_comb output gets a default first, otherwise a path that
   // skips an assignment infers a latch.
   always_comb begin
      hit      = 1'b0;
      hit_sel  = '0;
      hit_base = '0;
      for (int i = NREG - 1; i >= 0; i--) begin
         if (en_q[i] && (addr_q >= base_q[i]) && (addr_q <= limit_q[i])) begin
            hit      = 1'b1;
            hit_sel  = SEL_W'(i + 1);
            hit_base = base_q[i];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      dev_valid_d  = dev_valid_q;
      dev_sel_d    = dev_sel_q;
      dev_addr_d   = dev_addr_q;
      resp_valid_d = 1'b0;
      resp_err_d   = resp_err_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (hit) begin
               state_d     = S_WAIT;
               dev_valid_d = 1'b1;
               dev_sel_d   = hit_sel;
               dev_addr_d  = addr_q - hit_base;
               cnt_d       = '0;
            end else begin
               state_d      = S_RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
            end
         end
         S_WAIT: begin
            // An ack in the final WAIT cycle still completes cleanly.
            if (dev_ack || (cnt_q == CNT_LAST)) begin
               state_d      = S_RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = ~dev_ack;
               dev_valid_d  = 1'b0;
               dev_sel_d    = '0;
               dev_addr_d   = '0;
               cnt_d        = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_RESP: begin
            state_d    = S_IDLE;
            resp_err_d = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         cnt_q        <= '0;
         dev_valid_q  <= 1'b0;
         dev_sel_q    <= '0;
         dev_addr_q   <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         cnt_q        <= cnt_d;
         dev_valid_q  <= dev_valid_d;
         dev_sel_q    <= dev_sel_d;
         dev_addr_q   <= dev_addr_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign dev_valid  = dev_valid_q;
   assign dev_sel    = dev_sel_q;
   assign dev_addr   = dev_addr_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;

endmodule

// File: doc/memmap_router.md
MEMMAP_ROUTER -- requirements
Module: memmap_router

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning address width in bits.
REQ-002 SHALL have parameter NREG, default 4, meaning number of programmable regions (2..8).
REQ-003 SHALL have parameter SEL_W, default 3, meaning device-select width; SEL_W SHALL be at least clog2(NREG+1).
REQ-004 SHALL have parameter TIMEOUT, default 15, meaning device-wait cycles before error (1..255).
REQ-005 SHALL have port clk  in  1  sole clock; all logic rising-edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port cfg_we  in  1  write one region-table entry.
REQ-008 SHALL have port cfg_idx  in  clog2(NREG)  entry index.
REQ-009 SHALL have port cfg_base  in  ADDR_W  inclusive region start.
REQ-010 SHALL have port cfg_limit  in  ADDR_W  inclusive region end.
REQ-011 SHALL have port cfg_en  in  1  entry valid bit written with the entry.
REQ-012 SHALL have port req_valid  in  1  requester presents an address.
REQ-013 SHALL have port req_addr  in  ADDR_W  requested address.
REQ-014 SHALL have port req_ready  out  1  router accepts request.
REQ-015 SHALL have port dev_valid  out  1  device access active.
REQ-016 SHALL have port dev_sel  out  SEL_W  selected device, entry index+1; 0 = none.
REQ-017 SHALL have port dev_addr  out  ADDR_W  translated address, req_addr - base.
REQ-018 SHALL have port dev_ack  in  1  device completes access.
REQ-019 SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-020 SHALL have port resp_err  out  1  completion is an error; qualified by resp_valid.

Function
REQ-021 SHALL implement FSM states IDLE, DECODE, WAIT, RESP.
REQ-022 IDLE: req_ready=1; on req_valid, SHALL register req_addr and go to DECODE; otherwise stay.
REQ-023 DECODE: entry i SHALL match when enabled and base_i <= addr <= limit_i (unsigned, inclusive); base > limit SHALL never match.
REQ-024 DECODE, multiple matches: lowest index SHALL win.
REQ-025 DECODE hit: next cycle SHALL be WAIT with dev_valid=1, dev_sel=i+1, dev_addr=addr-base_i (ADDR_W bits, no wrap since addr>=base).
REQ-026 DECODE miss: next cycle SHALL be RESP with resp_err=1, dev_valid=0, dev_sel=0.
REQ-027 WAIT: dev_sel/dev_addr SHALL stay stable; wait counter starts at 0 on entry and increments each cycle without dev_ack.
REQ-028 WAIT, dev_ack=1: SHALL go to RESP, resp_err=0, dev_valid deasserted same edge.
REQ-029 WAIT, counter reaching TIMEOUT without ack: SHALL go to RESP, resp_err=1, dev_valid deasserted.
REQ-030 dev_ack on the same cycle the counter reaches TIMEOUT: ack SHALL win (resp_err=0).
REQ-031 RESP: resp_valid=1 for exactly one cycle; then IDLE; dev_sel and dev_addr SHALL return to 0.
REQ-032 Latency: accept to resp_valid SHALL be 2 cycles on miss; 3+N cycles on hit with ack after N WAIT cycles.
REQ-033 dev_ack outside WAIT SHALL be ignored.
REQ-034 cfg_we SHALL update entry cfg_idx at the clock edge in any state; a write in the same cycle as DECODE SHALL not affect that decode (old table used); in-flight WAIT outputs SHALL be unaffected.
REQ-035 Only one request SHALL be outstanding; req_ready=0 in all states except IDLE.

Reset
REQ-036 rst_n low SHALL immediately force IDLE, all table entries disabled with base=limit=0, counter=0, dev_valid=0, dev_sel=0, dev_addr=0, resp_valid=0, resp_err=0; req_ready=1 after release.
REQ-037 Reset mid-access SHALL abort without any resp_valid pulse.

Verification
REQ-038 After reset, request 0x0123 -> resp_valid with resp_err=1 two cycles after accept; dev_valid never asserted.
REQ-039 Entry0 0x0100..0xEFFF, entry1 0xF000..0xF010, request 0xF005 -> dev_sel=2, dev_addr=0x0005; ack after 2 cycles -> resp_err=0.
REQ-040 Overlap: entry0 0x0000..0x00FF, entry1 0x0080..0x0FFF, request 0x0080 -> dev_sel=1, dev_addr=0x0080; request 0x0100 -> dev_sel=2, dev_addr=0x0080.
REQ-041 Hit with no ack, TIMEOUT=15 -> resp_valid with resp_err=1 after 15 WAIT cycles; ack on cycle 15 -> resp_err=0.
REQ-042 Boundaries: entry 0xF000..0xF010, addresses 0xEFFF, 0xF000, 0xF010, 0xF011 -> miss, hit(0x0000), hit(0x0010), miss; entry base 0x20, limit 0x10 -> never hit.
REQ-043 rst_n low during WAIT -> outputs zero asynchronously, no resp_valid, table cleared, next request errors.
